vga_scanout: RTL and testbench

VGA_SCANOUT -- requirements
Module: VgaScanout

---
 rtl/vga_scanout.sv | 109 ++++++++++
 tb/tb_vga_scanout.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// VGA timing generator with a one-pixel-latency registered output stage.
// Counters and output registers advance only on pixel-enable cycles.
module vga_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_en,
    input  logic [23:0] i_rgb,
    output logic [9:0]  o_x,
    output logic [8:0]  o_y,
    output logic        o_visible,
    output logic        o_frame_start,
    output logic [7:0]  o_vga_r,
    output logic [7:0]  o_vga_g,
    output logic [7:0]  o_vga_b,
    output logic        o_vga_hs,
    output logic        o_vga_vs,
    output logic        o_vga_blank_n,
    output logic        o_vga_sync_n
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic [23:0] rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_n_q, blank_n_d;

    logic h_act, v_act, h_sync, v_sync;

    always_comb begin
        h_act  = (h_q < H_VIS);
        v_act  = (v_q < V_VIS);
        h_sync = (h_q >= HS_BEG) && (h_q < HS_END);
        v_sync = (v_q >= VS_BEG) && (v_q < VS_END);
    end

    always_comb begin
        h_d       = h_q;
        v_d       = v_q;
        rgb_d     = rgb_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        if (i_pix_en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
            rgb_d     = (h_act && v_act) ? i_rgb : 24'h000000;
            hs_d      = ~h_sync;
            vs_d      = ~v_sync;
            blank_n_d = h_act && v_act;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_q       <= '0;
            v_q       <= '0;
            rgb_q     <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            rgb_q     <= rgb_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
        end
    end

    assign o_visible     = h_act && v_act;
    assign o_x           = h_act ? h_q : '0;
    assign o_y           = v_act ? v_q[8:0] : '0;
    assign o_frame_start = (h_q == '0) && (v_q == '0) && i_pix_en;
    assign o_vga_r       = rgb_q[23:16];
    assign o_vga_g       = rgb_q[15:8];
    assign o_vga_b       = rgb_q[7:0];
    assign o_vga_hs      = hs_q;
    assign o_vga_vs      = vs_q;
    assign o_vga_blank_n = blank_n_q;
    assign o_vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a shrunken timing set; the model
// tracks a linear pixel position within the frame.
module tb_vga_scanout;

    localparam int HV = 16, HF = 4, HS = 6, HB = 4;
    localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_pix_en = 1'b0;
    logic [23:0] i_rgb = '0;
    logic [9:0]  o_x;
    logic [8:0]  o_y;
    logic        o_visible, o_frame_start;
    logic [7:0]  o_vga_r, o_vga_g, o_vga_b;
    logic        o_vga_hs, o_vga_vs, o_vga_blank_n, o_vga_sync_n;

    vga_scanout #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_pix_en(i_pix_en), .i_rgb(i_rgb),
        .o_x(o_x), .o_y(o_y), .o_visible(o_visible),
        .o_frame_start(o_frame_start),
        .o_vga_r(o_vga_r), .o_vga_g(o_vga_g), .o_vga_b(o_vga_b),
        .o_vga_hs(o_vga_hs), .o_vga_vs(o_vga_vs),
        .o_vga_blank_n(o_vga_blank_n), .o_vga_sync_n(o_vga_sync_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          x;
        int          y;
        bit          vis;
        bit          fs;
        logic [23:0] rgb;
        bit          hs;
        bit          vs;
        bit          blank_n;
        bit          cont;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // reference model state
    int          pos = 0;
    logic [23:0] m_rgb = '0;
    bit          m_hs = 1'b1, m_vs = 1'b1, m_blank_n = 1'b0;

    // aggregate observations over continuous-enable stretch
    int cont_idx = 0;
    int hs_low = 0, vs_low = 0, blank_hi = 0;
    int fs_seen = 0, last_fs = -1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst, input bit en,
                         input logic [23:0] rgb, input bit cont);
        exp_t e;
        int   h, v;
        bit   vis;
        @(negedge clk);
        i_rst    = rst;
        i_pix_en = en;
        i_rgb    = rgb;
        if (rst) begin
            pos = 0; m_rgb = '0; m_hs = 1'b1; m_vs = 1'b1; m_blank_n = 1'b0;
        end
        h   = pos % HT;
        v   = pos / HT;
        vis = (h < HV) && (v < VV);
        e.x       = (h < HV) ? h : 0;
        e.y       = (v < VV) ? v : 0;
        e.vis     = vis;
        e.fs      = (pos == 0) && en;
        e.rgb     = m_rgb;
        e.hs      = m_hs;
        e.vs      = m_vs;
        e.blank_n = m_blank_n;
        e.cont    = cont;
        q.push_back(e);
        if (!rst && en) begin
            m_rgb     = vis ? rgb : 24'h000000;
            m_hs      = !((h >= HV + HF) && (h < HV + HF + HS));
            m_vs      = !((v >= VV + VF) && (v < VV + VF + VS));
            m_blank_n = vis;
            pos       = (pos + 1) % FT;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("x", int'(o_x), e.x);
                check("y", int'(o_y), e.y);
                check("visible", int'(o_visible), int'(e.vis));
                check("frame_start", int'(o_frame_start), int'(e.fs));
                check("rgb", int'({o_vga_r, o_vga_g, o_vga_b}), int'(e.rgb));
                check("hs", int'(o_vga_hs), int'(e.hs));
                check("vs", int'(o_vga_vs), int'(e.vs));
                check("blank_n", int'(o_vga_blank_n), int'(e.blank_n));
                check("sync_n", int'(o_vga_sync_n), 0);
                if (e.cont) begin
                    if (cont_idx >= 1 && cont_idx <= FT) begin
                        hs_low   += (o_vga_hs == 1'b0) ? 1 : 0;
                        vs_low   += (o_vga_vs == 1'b0) ? 1 : 0;
                        blank_hi += (o_vga_blank_n == 1'b1) ? 1 : 0;
                    end
                    if (o_frame_start) begin
                        if (last_fs >= 0)
                            check("frame_period", cont_idx - last_fs, FT);
                        last_fs = cont_idx;
                        fs_seen++;
                    end
                    cont_idx++;
                end
            end
        end
    end

    initial begin : driver
        int guard;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 24'h123456, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 24'(32'($urandom)), 1'b0);
        // two full frames with continuous enable and a fixed colour
        for (int i = 0; i < 2 * FT + 5; i++) cycle(1'b0, 1'b1, 24'hFF8000, 1'b1);
        // alternate enable
        for (int i = 0; i < 8; i++)
            cycle(1'b0, (i % 2) == 0, 24'(32'($urandom)), 1'b0);
        // mid-frame reset at (10,5)
        guard = 0;
        while (pos != 5 * HT + 10 && guard < 2 * FT) begin
            cycle(1'b0, 1'b1, 24'(32'($urandom)), 1'b0);
            guard++;
        end
        check("reset_point_reached", pos, 5 * HT + 10);
        cycle(1'b1, 1'b1, 24'(32'($urandom)), 1'b0);
        cycle(1'b1, 1'b0, 24'(32'($urandom)), 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 24'(32'($urandom)), 1'b0);
        // randomized enable, colour and occasional reset
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0,
                  24'(32'($urandom)), 1'b0);
        @(negedge clk);
        #5;
        check("hs_low_per_frame", hs_low, HS * VT);
        check("vs_low_per_frame", vs_low, VS * HT);
        check("blank_hi_per_frame", blank_hi, HV * VV);
        check("frame_starts_seen", fs_seen, 3);
        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
